// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 8x32 register file: two buffered requesters (A = ALU,
// B = load) share one registered write port round-robin, with RAW hazard snooping.

module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic                     ready_o,
  output logic                     not_empty_o,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic [DEPTH-1:0]         slot_valid_o,
  output logic [DEPTH-1:0][AW-1:0] slot_addr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Ready looks only at the count, so a full FIFO stays closed even while popping.
  assign ready_o     = !rst && (count_q != CW'(DEPTH));
  assign not_empty_o = (count_q != '0);
  assign head_addr_o = addr_mem_q[rptr_q];
  assign head_data_o = data_mem_q[rptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop_i)  rptr_d = rptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_mem_q[wptr_q] <= push_addr_i;
      data_mem_q[wptr_q] <= push_data_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] offset;
    // A slot is live when its distance from the read pointer is below the count.
    assign offset          = PW'(i) - rptr_q;
    assign slot_valid_o[i] = ({1'b0, offset} < count_q);
    assign slot_addr_o[i]  = addr_mem_q[i];
  end

endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_data_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_data_i,
  output logic          we_o,
  output logic [AW-1:0] wa_o,
  output logic [DW-1:0] wd_o,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic          hazard1_o,
  output logic          hazard2_o,
  output logic          busy_o
);

  logic                     a_push, b_push;
  logic                     a_ne, b_ne;
  logic                     gnt_a, gnt_b;
  logic [AW-1:0]            a_head_addr, b_head_addr;
  logic [DW-1:0]            a_head_data, b_head_data;
  logic [DEPTH-1:0]         a_slot_valid, b_slot_valid;
  logic [DEPTH-1:0][AW-1:0] a_slot_addr, b_slot_addr;

  logic          last_a_q, last_a_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;

  assign a_push = a_valid_i && a_ready_o;
  assign b_push = b_valid_i && b_ready_o;

  regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
    .clk          (clk),
    .rst          (rst),
    .push_i       (a_push),
    .push_addr_i  (a_addr_i),
    .push_data_i  (a_data_i),
    .pop_i        (gnt_a),
    .ready_o      (a_ready_o),
    .not_empty_o  (a_ne),
    .head_addr_o  (a_head_addr),
    .head_data_o  (a_head_data),
    .slot_valid_o (a_slot_valid),
    .slot_addr_o  (a_slot_addr)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
    .clk          (clk),
    .rst          (rst),
    .push_i       (b_push),
    .push_addr_i  (b_addr_i),
    .push_data_i  (b_data_i),
    .pop_i        (gnt_b),
    .ready_o      (b_ready_o),
    .not_empty_o  (b_ne),
    .head_addr_o  (b_head_addr),
    .head_data_o  (b_head_data),
    .slot_valid_o (b_slot_valid),
    .slot_addr_o  (b_slot_addr)
  );

  // last_a_q=1 means A won the most recent grant, so B is favoured next contention.
  assign gnt_a = a_ne && (!b_ne || !last_a_q);
  assign gnt_b = b_ne && (!a_ne ||  last_a_q);

  always_comb begin
    last_a_d = last_a_q;
    we_d     = gnt_a || gnt_b;
    wa_d     = wa_q;
    wd_d     = wd_q;
    if (gnt_a) begin
      last_a_d = 1'b1;
      wa_d     = a_head_addr;
      wd_d     = a_head_data;
    end else if (gnt_b) begin
      last_a_d = 1'b0;
      wa_d     = b_head_addr;
      wd_d     = b_head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_a_q <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      last_a_q <= last_a_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign we_o   = we_q;
  assign wa_o   = wa_q;
  assign wd_o   = wd_q;
  assign busy_o = a_ne || b_ne || we_q;

  // The write being driven this cycle has not yet landed, so it still counts as pending.
  always_comb begin
    hazard1_o = we_q && (wa_q == ra1_i);
    hazard2_o = we_q && (wa_q == ra2_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (a_slot_valid[i] && (a_slot_addr[i] == ra1_i)) hazard1_o = 1'b1;
      if (b_slot_valid[i] && (b_slot_addr[i] == ra1_i)) hazard1_o = 1'b1;
      if (a_slot_valid[i] && (a_slot_addr[i] == ra2_i)) hazard2_o = 1'b1;
      if (b_slot_valid[i] && (b_slot_addr[i] == ra2_i)) hazard2_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-traced write sequences, backpressure,
// hazard flags and asynchronous reset behaviour.

module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 3;
  localparam int DW    = 32;

  logic          clk, rst;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_addr, b_addr, wa, ra1, ra2;
  logic [DW-1:0] a_data, b_data, wd;
  logic          we, hazard1, hazard2, busy;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready),
    .a_addr_i  (a_addr),
    .a_data_i  (a_data),
    .b_valid_i (b_valid),
    .b_ready_o (b_ready),
    .b_addr_i  (b_addr),
    .b_data_i  (b_data),
    .we_o      (we),
    .wa_o      (wa),
    .wd_o      (wd),
    .ra1_i     (ra1),
    .ra2_i     (ra2),
    .hazard1_o (hazard1),
    .hazard2_o (hazard2),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    if ({a_ready, b_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready_low got a=%b b=%b want 0 0", a_ready, b_ready);
    end
    total++;
    if ({we, wa, wd, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs got we=%b wa=%0d wd=%h busy=%b want all 0", we, wa, wd, busy);
    end
    total++;
    rst = 1'b0;
    #1;
    if ({a_ready, b_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_ready_high got a=%b b=%b want 1 1", a_ready, b_ready);
    end
    total++;
  endtask

  task automatic test_single_write();
    a_valid = 1'b1; a_addr = 3'd3; a_data = 32'h1234_5678;
    tick();
    a_valid = 1'b0;
    if ({we, busy} !== 2'b01) begin
      bad++; $display("FAIL single_queued got we=%b busy=%b want 0 1", we, busy);
    end
    total++;
    tick();
    if ({we, wa, wd} !== {1'b1, 3'd3, 32'h1234_5678}) begin
      bad++; $display("FAIL single_write got we=%b wa=%0d wd=%h want 1 3 12345678", we, wa, wd);
    end
    total++;
    tick();
    if ({we, busy} !== 2'b00) begin
      bad++; $display("FAIL single_idle got we=%b busy=%b want 0 0", we, busy);
    end
    total++;
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_wa [4];
    logic [DW-1:0] exp_wd [4];
    exp_wa = '{3'd1, 3'd5, 3'd2, 3'd6};
    exp_wd = '{32'hA000_0001, 32'hB000_0005, 32'hA000_0002, 32'hB000_0006};
    apply_reset();
    a_valid = 1'b1; a_addr = 3'd1; a_data = 32'hA000_0001;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 32'hB000_0005;
    tick();
    a_addr = 3'd2; a_data = 32'hA000_0002;
    b_addr = 3'd6; b_data = 32'hB000_0006;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({we, wa, wd} !== {1'b1, exp_wa[i], exp_wd[i]}) begin
        bad++; $display("FAIL contention_%0d got we=%b wa=%0d wd=%h want 1 %0d %h",
                        i, we, wa, wd, exp_wa[i], exp_wd[i]);
      end
      total++;
      tick();
    end
    if ({we, busy} !== 2'b00) begin
      bad++; $display("FAIL contention_idle got we=%b busy=%b want 0 0", we, busy);
    end
    total++;
  endtask

  task automatic test_drain_stream();
    logic [AW-1:0] addrs [3];
    addrs = '{3'd0, 3'd7, 3'd2};
    ra1 = 3'd0; ra2 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = addrs[i]; a_data = 32'hC000_0000 | 32'(addrs[i]);
      if (a_ready !== 1'b1) begin
        bad++; $display("FAIL stream_ready_%0d got %b want 1", i, a_ready);
      end
      total++;
      tick();
      if (i == 0 && hazard1 !== 1'b1) begin
        bad++; $display("FAIL stream_hazard_addr0 got %b want 1", hazard1);
      end
      if (i == 0) total++;
      if (i > 0 && {we, wa} !== {1'b1, addrs[i-1]}) begin
        bad++; $display("FAIL stream_write_%0d got we=%b wa=%0d want 1 %0d", i - 1, we, wa, addrs[i-1]);
      end
      if (i > 0) total++;
    end
    a_valid = 1'b0;
    tick();
    if ({we, wa, wd} !== {1'b1, 3'd2, 32'hC000_0002}) begin
      bad++; $display("FAIL stream_write_2 got we=%b wa=%0d wd=%h want 1 2 c0000002", we, wa, wd);
    end
    total++;
    tick();
    if ({we, busy, hazard1} !== 3'b000) begin
      bad++; $display("FAIL stream_idle got we=%b busy=%b hz1=%b want 0 0 0", we, busy, hazard1);
    end
    total++;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp_wa [6];
    logic          exp_ar [6];
    logic          exp_br [6];
    exp_wa = '{3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3};
    exp_ar = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_br = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    // A prior A-only write makes B the favoured side at the first contention.
    a_valid = 1'b1; a_addr = 3'd0; a_data = 32'hA000_0000;
    tick();
    a_valid = 1'b0;
    tick();
    a_valid = 1'b1; a_addr = 3'd1; a_data = 32'hA000_0001;
    b_valid = 1'b1; b_addr = 3'd4; b_data = 32'hB000_0004;
    tick();
    if (a_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_first got %b want 1", a_ready);
    end
    total++;
    a_addr = 3'd2; a_data = 32'hA000_0002;
    b_addr = 3'd5; b_data = 32'hB000_0005;
    tick();
    for (int i = 0; i < 6; i++) begin
      if ({we, wa} !== {1'b1, exp_wa[i]}) begin
        bad++; $display("FAIL bp_write_%0d got we=%b wa=%0d want 1 %0d", i, we, wa, exp_wa[i]);
      end
      total++;
      if ({a_ready, b_ready} !== {exp_ar[i], exp_br[i]}) begin
        bad++; $display("FAIL bp_ready_%0d got a=%b b=%b want %b %b",
                        i, a_ready, b_ready, exp_ar[i], exp_br[i]);
      end
      total++;
      if (i == 0) begin
        a_addr = 3'd3; a_data = 32'hA000_0003;
        b_addr = 3'd6; b_data = 32'hB000_0006;
      end
      if (i == 1) b_valid = 1'b0;
      if (i == 2) a_valid = 1'b0;
      tick();
    end
    if ({we, busy} !== 2'b00) begin
      bad++; $display("FAIL bp_idle got we=%b busy=%b want 0 0", we, busy);
    end
    total++;
  endtask

  task automatic test_hazard();
    apply_reset();
    ra1 = 3'd0; ra2 = 3'd7;
    #1;
    if ({hazard1, hazard2} !== 2'b00) begin
      bad++; $display("FAIL hazard_empty got %b%b want 00", hazard1, hazard2);
    end
    total++;
    ra1 = 3'd4;
    b_valid = 1'b1; b_addr = 3'd4; b_data = 32'hB000_0044;
    tick();
    b_valid = 1'b0;
    if ({hazard1, hazard2, we} !== 3'b100) begin
      bad++; $display("FAIL hazard_queued got hz1=%b hz2=%b we=%b want 1 0 0", hazard1, hazard2, we);
    end
    total++;
    tick();
    if ({hazard1, hazard2, we, wa} !== {3'b101, 3'd4}) begin
      bad++; $display("FAIL hazard_we got hz1=%b hz2=%b we=%b wa=%0d want 1 0 1 4", hazard1, hazard2, we, wa);
    end
    total++;
    tick();
    if ({hazard1, hazard2, we} !== 3'b000) begin
      bad++; $display("FAIL hazard_clear got hz1=%b hz2=%b we=%b want 0 0 0", hazard1, hazard2, we);
    end
    total++;
  endtask

  task automatic test_reset_midop();
    int writes = 0;
    apply_reset();
    ra1 = 3'd1; ra2 = 3'd2;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 32'hA000_0011;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 32'hB000_0022;
    for (int i = 0; i < 4; i++) tick();
    a_valid = 1'b0; b_valid = 1'b0;
    if ({hazard1, hazard2, busy, we} !== 4'b1111) begin
      bad++; $display("FAIL midop_loaded got hz1=%b hz2=%b busy=%b we=%b want 1 1 1 1", hazard1, hazard2, busy, we);
    end
    total++;
    #2 rst = 1'b1;
    #1;
    if ({we, wa, wd} !== '0) begin
      bad++; $display("FAIL midop_async_clear got we=%b wa=%0d wd=%h want 0 0 0", we, wa, wd);
    end
    total++;
    if ({busy, hazard1, hazard2, a_ready, b_ready} !== 5'b00000) begin
      bad++; $display("FAIL midop_flags got busy=%b hz=%b%b rdy=%b%b want 0 00 00",
                      busy, hazard1, hazard2, a_ready, b_ready);
    end
    total++;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (we !== 1'b0 || busy !== 1'b0) writes++;
    end
    if (writes != 0) begin
      bad++; $display("FAIL midop_no_writes got %0d active cycles want 0", writes);
    end
    total++;
    a_valid = 1'b1; a_addr = 3'd3; a_data = 32'hA000_0033;
    b_valid = 1'b1; b_addr = 3'd4; b_data = 32'hB000_0044;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    if ({we, wa, wd} !== {1'b1, 3'd3, 32'hA000_0033}) begin
      bad++; $display("FAIL midop_a_first got we=%b wa=%0d wd=%h want 1 3 a0000033", we, wa, wd);
    end
    total++;
    tick();
    if ({we, wa, wd} !== {1'b1, 3'd4, 32'hB000_0044}) begin
      bad++; $display("FAIL midop_b_second got we=%b wa=%0d wd=%h want 1 4 b0000044", we, wa, wd);
    end
    total++;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    ra1 = 3'd6; ra2 = 3'd6;
    test_reset();
    test_single_write();
    test_contention();
    test_drain_stream();
    test_backpressure();
    test_hazard();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
